// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: access size and FSM state
// encodings, plus helpers that turn a (size, low address bits) pair into byte
// enables and an illegal-access flag.
package sram_like_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AWAIT = 2'd1,
    ST_DWAIT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Lane mask for an aligned access; the caller masks it off for illegal accesses.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Misaligned half/word or the reserved size encoding.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sram_like_responder_spram_be.sv
// Single-port word RAM with four byte-lane write enables and a registered,
// read-first output. The output register only updates when en is high, so the
// last read word is held between accesses. The array itself is never reset.
module spram_be #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Capture the pre-write word on an access, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[idx];
  end

  // Output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= 32'h0;
    else     rdata_q <= rdata_d;
  end

  // Byte-lane writes into the array.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like slave with programmable accept and response delays. One request
// may be outstanding; the memory access (read-first, then byte-masked write)
// happens on the edge that enters RESP, where data_ok is high for one cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no request held; addr_ok immediate when addr_delay is 0
//   ST_AWAIT | counting down the accept delay while req stays high
//   ST_DWAIT | request accepted, counting down the response delay
//   ST_RESP  | data_ok high for this single cycle, rdata valid
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  addr_delay,
  input  logic [3:0]  data_delay,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          data_ok_q, data_ok_d;
  logic          err_q, err_d;

  logic          addr_ok_c;
  logic          hs;
  logic          go_resp;
  logic          eff_wr;
  logic [1:0]    eff_size;
  logic [AW+1:0] eff_addr;
  logic [31:0]   eff_wdata;
  logic          eff_bad;
  logic          ram_en;
  logic [3:0]    ram_we;

  // Upper address bits alias onto the same words.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  // Next-state, down-counters, request latch and RAM strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    addr_ok_c = 1'b0;
    go_resp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (addr_delay == 4'd0) begin
            addr_ok_c = 1'b1;
          end else begin
            state_d = ST_AWAIT;
            cnt_d   = addr_delay;
          end
        end
      end
      ST_AWAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          addr_ok_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DWAIT: begin
        if (cnt_q == 4'd1) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    hs = addr_ok_c & req & ~rst;

    if (hs) begin
      wr_d    = wr;
      size_d  = size;
      addr_d  = addr[AW+1:0];
      wdata_d = wdata;
      if (data_delay == 4'd0) begin
        go_resp = 1'b1;
      end else begin
        state_d = ST_DWAIT;
        cnt_d   = data_delay;
      end
    end

    if (go_resp) begin
      state_d = ST_RESP;
      cnt_d   = 4'd0;
    end

    // A zero response delay accesses the RAM on the handshake edge itself,
    // before the request has been latched, so bypass the latch then.
    eff_wr    = hs ? wr           : wr_q;
    eff_size  = hs ? size         : size_q;
    eff_addr  = hs ? addr[AW+1:0] : addr_q;
    eff_wdata = hs ? wdata        : wdata_q;
    eff_bad   = access_bad(eff_size, eff_addr[1:0]);

    ram_en    = go_resp & ~rst;
    ram_we    = (ram_en & eff_wr & ~eff_bad) ? byte_en(eff_size, eff_addr[1:0]) : 4'b0000;
    data_ok_d = go_resp;
    err_d     = err_q | (go_resp & eff_bad);
  end

  // State, counter, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
    end
  end

  spram_be #(.AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (eff_addr[AW+1:2]),
    .wdata (eff_wdata),
    .rdata (rdata)
  );

  assign addr_ok = addr_ok_c & ~rst;
  assign data_ok = data_ok_q;
  assign err     = err_q;

endmodule
